// File: rtl/tm1640_refresh_ctrl_pkg.sv
// tm1640_pkg
// Shared definitions for the TM1640 refresh controller.
// Contents:
//   CMD_DATA_AUTO / CMD_ADDR0 / CMD_CTRL : TM1640 command bytes
//   SEG_TABLE                            : hex digit -> gfedcba segment pattern
//   state_t                              : sequencer states
package tm1640_pkg;

   localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
   localparam logic [7:0] CMD_ADDR0     = 8'hC0;
   localparam logic [7:0] CMD_CTRL      = 8'h80;

   // Index 0 is the rightmost entry, so the list reads F down to 0.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

endpackage

// File: rtl/tm1640_refresh_ctrl_if.sv
// tm1640_refresh_ctrl_if
// Byte handshake between the refresh controller and the TM1640 serializer.
// Signals:
//   tm_latch : byte-valid strobe from the controller
//   tm_byte  : byte to shift out
//   tm_stop  : issue a stop condition after this byte
//   tm_busy  : serializer is shifting a byte
// Modports: master = controller side, slave = serializer side.
interface tm1640_refresh_ctrl_if;

   logic       tm_latch;
   logic [7:0] tm_byte;
   logic       tm_stop;
   logic       tm_busy;

   modport master (
      output tm_latch,
      output tm_byte,
      output tm_stop,
      input  tm_busy
   );

   modport slave (
      input  tm_latch,
      input  tm_byte,
      input  tm_stop,
      output tm_busy
   );

endinterface

// File: rtl/tm1640_refresh_ctrl_seg_encode.sv
// tm1640_seg_encode
// Combinational hex-to-segment encoder for one digit.
// Ports:
//   hex   in  4  digit value
//   dp    in  1  decimal point
//   blank in  1  force the byte to 0x00 (decimal point suppressed too)
//   seg   out 8  {dp, gfedcba}
module tm1640_seg_encode
   import tm1640_pkg::*;
(
   input  logic [3:0] hex,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);

   always_comb begin
      seg = {dp, SEG_TABLE[hex]};
      if (blank) begin
         seg = 8'h00;
      end
   end

endmodule

// File: rtl/tm1640_refresh_ctrl.sv
// tm1640_refresh_ctrl
// Turns a parallel display image into a complete TM1640 frame:
// data command, address 0, one segment byte per digit, display control.
// Frames start on request or periodically and are handed byte by byte to
// the serializer through the latch/busy handshake.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   update      : request a frame (level-sampled, coalesced while busy)
//   digits      : 4 bits per digit, digit 0 in [3:0] and sent first
//   dp, blank   : per-digit decimal point / blanking
//   disp_on     : display enable
//   brightness  : pulse-width setting
//   ready       : idle with nothing pending
//   frame_done  : one-cycle pulse after the last byte completes
//   tm          : serializer handshake (master side)
module tm1640_refresh_ctrl
   import tm1640_pkg::*;
#(
   parameter int DIGITS      = 9,
   parameter int AUTO_PERIOD = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  update,
   input  logic [4*DIGITS-1:0]   digits,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  disp_on,
   input  logic [2:0]            brightness,
   output logic                  ready,
   output logic                  frame_done,
   tm1640_refresh_ctrl_if.master tm
);

   localparam int             SW              = 5;
   localparam logic [SW-1:0]  LAST_STEP       = SW'(DIGITS + 2);
   localparam logic [SW-1:0]  LAST_DIGIT_STEP = SW'(DIGITS + 1);

   state_t                state;
   state_t                state_next;
   logic [SW-1:0]         s;
   logic [SW-1:0]         digit_idx;
   logic                  pending;
   logic                  start;
   logic                  auto_fire;
   logic                  step_done;
   logic                  last_done;

   logic [4*DIGITS-1:0]   snap_digits;
   logic [DIGITS-1:0]     snap_dp;
   logic [DIGITS-1:0]     snap_blank;
   logic                  snap_disp_on;
   logic [2:0]            snap_brightness;

   logic [3:0]            sel_hex;
   logic                  sel_dp;
   logic                  sel_blank;
   logic [7:0]            seg_byte;
   logic [7:0]            step_byte;
   logic                  step_stop;

   assign start     = (state == IDLE) && (update || pending || auto_fire);
   assign step_done = (state == WAIT_DONE) && !tm.tm_busy;
   assign last_done = step_done && (s == LAST_STEP);

   // Idle-time refresh counter. It is held at zero whenever a frame is in
   // flight, so the period is measured from the end of the previous frame.
   generate
      if (AUTO_PERIOD > 0) begin : g_auto
         localparam int CW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
         logic [CW-1:0] auto_cnt;

         always_ff @(posedge clk) begin
            if (rst || state != IDLE || start) begin
               auto_cnt <= '0;
            end else begin
               auto_cnt <= auto_cnt + CW'(1);
            end
         end

         assign auto_fire = (state == IDLE) && (auto_cnt == CW'(AUTO_PERIOD - 1));
      end else begin : g_no_auto
         assign auto_fire = 1'b0;
      end
   endgenerate

   // State register plus the step counter, request flag and input snapshot.
   // The snapshot is taken on the start edge so input changes mid-frame
   // only show up in the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         s               <= '0;
         pending         <= 1'b0;
         frame_done      <= 1'b0;
         snap_digits     <= '0;
         snap_dp         <= '0;
         snap_blank      <= '0;
         snap_disp_on    <= 1'b0;
         snap_brightness <= '0;
      end else begin
         state      <= state_next;
         frame_done <= last_done;

         if (start) begin
            s               <= '0;
            snap_digits     <= digits;
            snap_dp         <= dp;
            snap_blank      <= blank;
            snap_disp_on    <= disp_on;
            snap_brightness <= brightness;
         end else if (step_done && !last_done) begin
            s <= s + SW'(1);
         end

         if (start) begin
            pending <= 1'b0;
         end else if (update && state != IDLE) begin
            pending <= 1'b1;
         end
      end
   end

   // Next-state logic. When the serializer is already free at the start
   // edge the ISSUE cycle is folded into the start transition, which gives
   // the one-cycle request-to-latch latency; otherwise ISSUE waits for
   // busy to drop before latching.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = tm.tm_busy ? ISSUE : WAIT_ACK;
            end
         end
         ISSUE: begin
            if (!tm.tm_busy) begin
               state_next = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (tm.tm_busy) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!tm.tm_busy) begin
               state_next = (s == LAST_STEP) ? IDLE : ISSUE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Pick the snapshot digit addressed by the current step so a single
   // encoder serves every position.
   always_comb begin
      digit_idx = s - SW'(2);
      sel_hex   = '0;
      sel_dp    = 1'b0;
      sel_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_idx == SW'(i)) begin
            sel_hex   = snap_digits[4*i +: 4];
            sel_dp    = snap_dp[i];
            sel_blank = snap_blank[i];
         end
      end
   end

   tm1640_seg_encode u_seg (
      .hex   (sel_hex),
      .dp    (sel_dp),
      .blank (sel_blank),
      .seg   (seg_byte)
   );

   // Byte and stop flag for each step of the frame. The data command and
   // the final digit close their transfers with a stop; the address byte
   // runs straight into the digit data.
   always_comb begin
      step_byte = seg_byte;
      step_stop = (s == LAST_DIGIT_STEP);
      if (s == '0) begin
         step_byte = CMD_DATA_AUTO;
         step_stop = 1'b1;
      end else if (s == SW'(1)) begin
         step_byte = CMD_ADDR0;
         step_stop = 1'b0;
      end else if (s == LAST_STEP) begin
         step_byte = CMD_CTRL | {4'b0000, snap_disp_on, snap_brightness};
         step_stop = 1'b1;
      end
   end

   // Outputs are decoded from the state register. The byte and stop flag
   // are only presented while the latch is up, and the step counter cannot
   // move during WAIT_ACK, so they stay stable for the whole strobe.
   always_comb begin
      tm.tm_latch = (state == WAIT_ACK);
      tm.tm_byte  = (state == WAIT_ACK) ? step_byte : 8'h00;
      tm.tm_stop  = (state == WAIT_ACK) ? step_stop : 1'b0;
      ready       = (state == IDLE) && !pending && !update;
   end

endmodule

// File: tb/tb_tm1640_refresh_ctrl.sv
// tb_tm1640_refresh_ctrl
// Directed bench for tm1640_refresh_ctrl. Two instances share the display
// inputs: dut (no auto refresh) takes directed update pulses, dut2
// (AUTO_PERIOD=100) is left free-running to exercise periodic refresh.
// Each instance talks to a small serializer model with programmable busy
// length; captured bytes are compared against hand-computed frames.
module tb_tm1640_refresh_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        update;
   logic [35:0] digits;
   logic [8:0]  dp;
   logic [8:0]  blank;
   logic        disp_on;
   logic [2:0]  brightness;
   logic        ready;
   logic        frame_done;
   logic        ready2;
   logic        frame_done2;

   int tests_run    = 0;
   int tests_failed = 0;
   int cycle        = 0;

   tm1640_refresh_ctrl_if tm1 ();
   tm1640_refresh_ctrl_if tm2 ();

   tm1640_refresh_ctrl #(.DIGITS(9), .AUTO_PERIOD(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .update     (update),
      .digits     (digits),
      .dp         (dp),
      .blank      (blank),
      .disp_on    (disp_on),
      .brightness (brightness),
      .ready      (ready),
      .frame_done (frame_done),
      .tm         (tm1)
   );

   tm1640_refresh_ctrl #(.DIGITS(9), .AUTO_PERIOD(100)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .update     (1'b0),
      .digits     (digits),
      .dp         (dp),
      .blank      (blank),
      .disp_on    (disp_on),
      .brightness (brightness),
      .ready      (ready2),
      .frame_done (frame_done2),
      .tm         (tm2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Hand-computed frames, {stop, byte}.
   logic [8:0] exp_a [12] = '{9'h140, 9'h0C0, 9'h006, 9'h05B, 9'h04F, 9'h066,
                              9'h06D, 9'h07D, 9'h007, 9'h07F, 9'h16F, 9'h18F};
   logic [8:0] exp_b [12] = '{9'h140, 9'h0C0, 9'h0F7, 9'h05B, 9'h04F, 9'h066,
                              9'h000, 9'h07D, 9'h007, 9'h07F, 9'h16F, 9'h183};

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [35:0] d, input logic [8:0] p, input logic [8:0] b,
                                input logic on, input logic [2:0] br);
      digits     = d;
      dp         = p;
      blank      = b;
      disp_on    = on;
      brightness = br;
   endtask

   // Serializer model for dut: accepts a latched byte when idle and stays
   // busy for busy_len cycles (or cycles through 1/5/40 in vary mode).
   int         busy_len   = 1;
   bit         vary_mode  = 1'b0;
   int         lens [3]   = '{1, 5, 40};
   int         cnt1       = 0;
   int         accepts1   = 0;
   logic [8:0] cap_q [$];

   always @(posedge clk) begin
      if (rst) begin
         tm1.tm_busy <= 1'b0;
         cnt1        <= 0;
      end else if (cnt1 != 0) begin
         cnt1 <= cnt1 - 1;
         if (cnt1 == 1) tm1.tm_busy <= 1'b0;
      end else if (tm1.tm_latch && !tm1.tm_busy) begin
         tm1.tm_busy <= 1'b1;
         cnt1        <= vary_mode ? lens[accepts1 % 3] : busy_len;
         accepts1    <= accepts1 + 1;
         cap_q.push_back({tm1.tm_stop, tm1.tm_byte});
      end
   end

   // Serializer model for dut2, fixed one-cycle busy.
   int cnt2 = 0;

   always @(posedge clk) begin
      if (rst) begin
         tm2.tm_busy <= 1'b0;
         cnt2        <= 0;
      end else if (cnt2 != 0) begin
         cnt2 <= cnt2 - 1;
         if (cnt2 == 1) tm2.tm_busy <= 1'b0;
      end else if (tm2.tm_latch && !tm2.tm_busy) begin
         tm2.tm_busy <= 1'b1;
         cnt2        <= 1;
      end
   end

   // Handshake monitor for dut: latch/busy pulse counts, byte stability
   // while latched, and the two-cycle gap from busy fall to next latch.
   logic       prev_latch  = 1'b0;
   logic       prev_busy   = 1'b0;
   logic [8:0] held_val    = '0;
   int         latch_rises = 0;
   int         busy_rises  = 0;
   int         stab_err    = 0;
   int         done_count  = 0;
   int         last_fall   = -1;

   always @(negedge clk) begin
      if (rst) begin
         prev_latch = 1'b0;
         prev_busy  = 1'b0;
         last_fall  = -1;
      end else begin
         if (tm1.tm_latch && !prev_latch) begin
            latch_rises++;
            held_val = {tm1.tm_stop, tm1.tm_byte};
            if (last_fall >= 0) begin
               checkOutput("byte gap", cycle - last_fall, 2);
               last_fall = -1;
            end
         end else if (tm1.tm_latch && ({tm1.tm_stop, tm1.tm_byte} != held_val)) begin
            stab_err++;
         end
         if (tm1.tm_busy && !prev_busy) busy_rises++;
         if (!tm1.tm_busy && prev_busy) last_fall = cycle;
         if (frame_done) begin
            done_count++;
            last_fall = -1;
         end
         prev_latch = tm1.tm_latch;
         prev_busy  = tm1.tm_busy;
      end
   end

   // Auto-refresh monitor for dut2: each ready fall must come exactly 100
   // cycles after the previous frame_done and coincide with the first latch.
   int   done_cycle2 = -1;
   int   auto_frames = 0;
   logic prev_ready2 = 1'b1;

   always @(negedge clk) begin
      if (rst) begin
         done_cycle2 = -1;
         prev_ready2 = 1'b1;
      end else begin
         if (prev_ready2 && !ready2) begin
            auto_frames++;
            checkOutput("auto latch at start", 32'(tm2.tm_latch), 1);
            if (done_cycle2 >= 0) checkOutput("auto period", cycle - done_cycle2, 100);
         end
         if (frame_done2) done_cycle2 = cycle;
         prev_ready2 = ready2;
      end
   end

   task automatic waitFrameDone(input string tag, input int max_cycles);
      logic seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(negedge clk);
         #1;
         if (frame_done) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 1);
   endtask

   task automatic pulseUpdate();
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
   endtask

   task automatic compareFrame(input string tag, input int offset, input logic [8:0] exp [12]);
      if (cap_q.size() >= offset + 12) begin
         for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("%s byte%0d", tag, i), 32'(cap_q[offset + i]), 32'(exp[i]));
         end
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lr0, br0, done0, acc0, acc_rst;

      rst    = 1'b1;
      update = 1'b0;
      applyStimulus(36'h0, 9'h0, 9'h0, 1'b0, 3'd0);

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset tm_latch",   32'(tm1.tm_latch), 0);
      checkOutput("reset tm_byte",    32'(tm1.tm_byte),  0);
      checkOutput("reset tm_stop",    32'(tm1.tm_stop),  0);
      checkOutput("reset frame_done", 32'(frame_done),   0);
      checkOutput("reset ready",      32'(ready),        1);
      checkOutput("reset ready2",     32'(ready2),       1);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Basic frame: latency, byte sequence, frame_done pulse
      applyStimulus(36'h987654321, 9'h000, 9'h000, 1'b1, 3'd7);
      busy_len = 1;
      cap_q.delete();
      update = 1'b1;
      #1;
      checkOutput("ready low with update", 32'(ready), 0);
      @(negedge clk);
      update = 1'b0;
      #1;
      checkOutput("start latch",  32'(tm1.tm_latch), 1);
      checkOutput("start byte",   32'(tm1.tm_byte),  'h40);
      checkOutput("start stop",   32'(tm1.tm_stop),  1);
      waitFrameDone("frame A done", 500);
      checkOutput("ready at frame_done", 32'(ready), 1);
      checkOutput("frame A size", cap_q.size(), 12);
      compareFrame("frame A", 0, exp_a);
      @(negedge clk);
      #1;
      checkOutput("frame_done single cycle", 32'(frame_done), 0);

      // Varying serializer busy lengths
      repeat (5) @(negedge clk);
      cap_q.delete();
      vary_mode = 1'b1;
      lr0 = latch_rises;
      br0 = busy_rises;
      pulseUpdate();
      waitFrameDone("vary frame done", 2000);
      vary_mode = 1'b0;
      checkOutput("vary frame size", cap_q.size(), 12);
      compareFrame("vary frame", 0, exp_a);
      checkOutput("latch stability errors", stab_err, 0);
      checkOutput("vary latch count", latch_rises - lr0, 12);
      checkOutput("vary busy pulses", busy_rises - br0, 12);

      // Coalesced requests during a frame, new inputs for the follow-up
      repeat (5) @(negedge clk);
      cap_q.delete();
      busy_len = 5;
      done0 = done_count;
      pulseUpdate();
      repeat (10) @(negedge clk);
      pulseUpdate();
      repeat (9) @(negedge clk);
      pulseUpdate();
      repeat (9) @(negedge clk);
      pulseUpdate();
      repeat (5) @(negedge clk);
      applyStimulus(36'h98765432A, 9'h001, 9'h010, 1'b0, 3'd3);
      waitFrameDone("coalesce first done", 1000);
      checkOutput("ready low with pending", 32'(ready), 0);
      waitFrameDone("coalesce second done", 1000);
      checkOutput("ready after second frame", 32'(ready), 1);
      repeat (200) @(negedge clk);
      #1;
      checkOutput("coalesce frame count", done_count - done0, 2);
      checkOutput("coalesce byte count", cap_q.size(), 24);
      compareFrame("coalesce frame A", 0, exp_a);
      compareFrame("frame B", 12, exp_b);

      // Reset during step 5
      applyStimulus(36'h987654321, 9'h000, 9'h000, 1'b1, 3'd7);
      acc0 = accepts1;
      pulseUpdate();
      for (int i = 0; i < 500 && (accepts1 - acc0) < 6; i++) @(negedge clk);
      checkOutput("reached step 5", accepts1 - acc0, 6);
      acc_rst = accepts1;
      lr0     = latch_rises;
      done0   = done_count;
      rst     = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("mid-frame reset latch", 32'(tm1.tm_latch), 0);
      checkOutput("mid-frame reset ready", 32'(ready),        1);
      checkOutput("mid-frame reset byte",  32'(tm1.tm_byte),  0);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      #1;
      checkOutput("no latch after reset",    latch_rises - lr0,  0);
      checkOutput("no bytes after reset",    accepts1 - acc_rst, 0);
      checkOutput("no frame_done after reset", done_count - done0, 0);

      // Periodic refresh on dut2 has been running alongside
      repeat (250) @(negedge clk);
      #1;
      checkOutput("auto frames seen", 32'(auto_frames >= 3), 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
